// File: rtl/seg_scan_display_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan display:
// segment codes (active-high {g,f,e,d,c,b,a}), digit-slot indices and the
// per-frame snapshot record.
package seg_scan_display_pkg;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_0     = 7'h3F;
    localparam logic [6:0] SEG7_1     = 7'h06;
    localparam logic [6:0] SEG7_2     = 7'h5B;
    localparam logic [6:0] SEG7_3     = 7'h4F;
    localparam logic [6:0] SEG7_4     = 7'h66;
    localparam logic [6:0] SEG7_5     = 7'h6D;
    localparam logic [6:0] SEG7_6     = 7'h7D;
    localparam logic [6:0] SEG7_7     = 7'h07;
    localparam logic [6:0] SEG7_8     = 7'h7F;
    localparam logic [6:0] SEG7_9     = 7'h6F;
    localparam logic [6:0] SEG7_DASH  = 7'h40;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    // Digit-slot indices, rightmost digit is slot 0
    localparam logic [1:0] SLOT_MIN_LOW   = 2'd0;
    localparam logic [1:0] SLOT_MIN_HIGH  = 2'd1;
    localparam logic [1:0] SLOT_HOUR_LOW  = 2'd2;
    localparam logic [1:0] SLOT_HOUR_HIGH = 2'd3;

    // Everything that is frozen for the duration of one display frame
    typedef struct packed {
        logic [3:0] hour_high;
        logic [3:0] hour_low;
        logic [3:0] min_high;
        logic [3:0] min_low;
        logic [3:0] blink_mask;
        logic       blank_lead;
    } snap_t;

endpackage

// File: rtl/seg_scan_display_if.sv
// Digit/control inputs from the clock core and the board-facing segment and
// digit-enable pins of the scan display, grouped as one interface.
interface seg_scan_display_if;

    logic [3:0] hour_high;
    logic [3:0] hour_low;
    logic [3:0] min_high;
    logic [3:0] min_low;
    logic [3:0] blink_mask;
    logic       blank_lead;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_sel;

    // Clock core / bench side: supplies digits, observes pins
    modport master (
        output hour_high, hour_low, min_high, min_low, blink_mask, blank_lead,
        input  seg, dp, dig_sel
    );

    // Display driver side
    modport slave (
        input  hour_high, hour_low, min_high, min_low, blink_mask, blank_lead,
        output seg, dp, dig_sel
    );

endinterface

// File: rtl/seg_scan_display_bcd_to_seg7.sv
// Purely combinational BCD to active-high 7-segment decoder. Non-decimal
// codes 10..15 show a dash so corrupted digits are visible rather than hidden.
module bcd_to_seg7
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        seg_o = SEG7_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG7_0;
            4'd1:    seg_o = SEG7_1;
            4'd2:    seg_o = SEG7_2;
            4'd3:    seg_o = SEG7_3;
            4'd4:    seg_o = SEG7_4;
            4'd5:    seg_o = SEG7_5;
            4'd6:    seg_o = SEG7_6;
            4'd7:    seg_o = SEG7_7;
            4'd8:    seg_o = SEG7_8;
            4'd9:    seg_o = SEG7_9;
            default: seg_o = SEG7_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// 4-digit multiplexed 7-segment scan driver. Each slot lights one digit after
// a short all-off window (anti-ghosting); digits and blink controls are
// frozen once per frame so a time update never tears across digits.
module seg_scan_display #(
    parameter int SLOT_CYC       = 12000,
    parameter int BLANK_CYC      = 120,
    parameter int COLON_SLOTS    = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_display_if.slave disp
);

    import seg_scan_display_pkg::*;

    localparam int SLOT_W  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int COLON_W = (COLON_SLOTS > 1) ? $clog2(COLON_SLOTS) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0]  BLANK_LIM  = SLOT_W'(BLANK_CYC);
    localparam logic [COLON_W-1:0] COLON_LAST = COLON_W'(COLON_SLOTS - 1);

    localparam bit         SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam bit         DIG_LOW = (DIG_ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = SEG_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_LOW;
    localparam logic [3:0] DIG_OFF = DIG_LOW ? 4'hF : 4'h0;

    logic [SLOT_W-1:0]  slot_cnt_q,  slot_cnt_d;
    logic [1:0]         slot_idx_q,  slot_idx_d;
    logic [COLON_W-1:0] colon_cnt_q, colon_cnt_d;
    logic               colon_ph_q,  colon_ph_d;
    snap_t              snap_q,      snap_d;
    logic [6:0]         seg_q,       seg_d;
    logic               dp_q,        dp_d;
    logic [3:0]         dig_q,       dig_d;

    logic       slot_wrap;
    logic [3:0] cur_digit;
    logic [6:0] dec_seg;

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    // Slot/colon counters and once-per-frame snapshot of the inputs
    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        slot_idx_d  = slot_wrap ? slot_idx_q + 2'd1 : slot_idx_q;
        colon_cnt_d = colon_cnt_q;
        colon_ph_d  = colon_ph_q;
        if (slot_wrap) begin
            if (colon_cnt_q == COLON_LAST) begin
                colon_cnt_d = '0;
                colon_ph_d  = ~colon_ph_q;
            end else begin
                colon_cnt_d = colon_cnt_q + 1'b1;
            end
        end
        snap_d = snap_q;
        if (slot_wrap && (slot_idx_q == SLOT_HOUR_HIGH)) begin
            snap_d.hour_high  = disp.hour_high;
            snap_d.hour_low   = disp.hour_low;
            snap_d.min_high   = disp.min_high;
            snap_d.min_low    = disp.min_low;
            snap_d.blink_mask = disp.blink_mask;
            snap_d.blank_lead = disp.blank_lead;
        end
    end

    // Select the frozen digit belonging to the current slot
    always_comb begin
        cur_digit = snap_q.min_low;
        case (slot_idx_q)
            SLOT_MIN_HIGH:  cur_digit = snap_q.min_high;
            SLOT_HOUR_LOW:  cur_digit = snap_q.hour_low;
            SLOT_HOUR_HIGH: cur_digit = snap_q.hour_high;
            default:        cur_digit = snap_q.min_low;
        endcase
    end

    // Blank window, digit blanking, colon and pin polarity for the next output
    always_comb begin
        logic       in_blank;
        logic       digit_blank;
        logic [6:0] lit_seg;
        logic       lit_dp;
        logic [3:0] lit_dig;

        in_blank    = (slot_cnt_q < BLANK_LIM);
        digit_blank = (snap_q.blink_mask[slot_idx_q] && !colon_ph_q)
                    || ((slot_idx_q == SLOT_HOUR_HIGH) && snap_q.blank_lead
                        && (snap_q.hour_high == 4'd0));
        lit_seg     = (in_blank || digit_blank) ? SEG7_BLANK : dec_seg;
        lit_dp      = !in_blank && (slot_idx_q == SLOT_HOUR_LOW) && colon_ph_q;
        lit_dig     = in_blank ? 4'b0000 : (4'b0001 << slot_idx_q);

        seg_d = SEG_LOW ? ~lit_seg : lit_seg;
        dp_d  = SEG_LOW ? ~lit_dp  : lit_dp;
        dig_d = DIG_LOW ? ~lit_dig : lit_dig;
    end

    // State and output registers; reset forces all pins to the unlit level
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            slot_cnt_q  <= '0;
            slot_idx_q  <= SLOT_MIN_LOW;
            colon_cnt_q <= '0;
            colon_ph_q  <= 1'b0;
            snap_q      <= '0;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            dig_q       <= DIG_OFF;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            slot_idx_q  <= slot_idx_d;
            colon_cnt_q <= colon_cnt_d;
            colon_ph_q  <= colon_ph_d;
            snap_q      <= snap_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_q       <= dig_d;
        end
    end

    assign disp.seg     = seg_q;
    assign disp.dp      = dp_q;
    assign disp.dig_sel = dig_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with small scan parameters
// (16-cycle slots, 2-cycle blank window, colon toggling every 4 slots, i.e.
// once per 64-cycle frame). Expected pin values are hand-computed per
// (frame, slot, slot_cnt) point and queued; a negedge monitor compares them.
module tb_seg_scan_display;

    localparam int SLOT_CYC    = 16;
    localparam int BLANK_CYC   = 2;
    localparam int COLON_SLOTS = 4;

    typedef struct {
        int         k;
        string      tag;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    seg_scan_display_if dif ();

    seg_scan_display #(
        .SLOT_CYC       (SLOT_CYC),
        .BLANK_CYC      (BLANK_CYC),
        .COLON_SLOTS    (COLON_SLOTS),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge k presents the state of scan position k-1
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Edge index at which the output for (frame, slot, slot_cnt) is visible
    function automatic int kk(input int f, input int s, input int c);
        return f * 4 * SLOT_CYC + s * SLOT_CYC + c + 1;
    endfunction

    task automatic expect_at(input int k, input string tag, input logic [6:0] seg,
                             input logic dp, input logic [3:0] dig);
        exp_t e;
        e.k = k; e.tag = tag; e.seg = seg; e.dp = dp; e.dig = dig;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) check("wait_timeout", cyc, n);
    endtask

    // Monitor: compare every queued expectation on its edge
    always @(negedge clk) begin
        if (!rst) begin
            while (sb_q.size() > 0 && sb_q[0].k <= cyc) begin
                mon_e = sb_q.pop_front();
                if (mon_e.k != cyc)
                    check({mon_e.tag, "_missed"}, cyc, mon_e.k);
                else
                    check(mon_e.tag, {20'd0, dif.seg, dif.dp, dif.dig_sel},
                          {20'd0, mon_e.seg, mon_e.dp, mon_e.dig});
            end
        end
    end

    initial begin
        dif.hour_high  = 4'd1;
        dif.hour_low   = 4'd2;
        dif.min_high   = 4'd3;
        dif.min_low    = 4'd4;
        dif.blink_mask = 4'b0000;
        dif.blank_lead = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", {20'd0, dif.seg, dif.dp, dif.dig_sel}, {20'd0, 7'h7F, 1'b1, 4'hF});

        // Frame 0: reset snapshot of zeros, colon off
        expect_at(kk(0, 0, 0), "f0_blank_c0",  7'h7F, 1'b1, 4'hF);
        expect_at(kk(0, 0, 1), "f0_blank_c1",  7'h7F, 1'b1, 4'hF);
        expect_at(kk(0, 0, 2), "f0_first_lit", 7'h40, 1'b1, 4'hE);
        expect_at(kk(0, 2, 5), "f0_slot2",     7'h40, 1'b1, 4'hB);
        expect_at(kk(0, 3, 8), "f0_slot3",     7'h40, 1'b1, 4'h7);
        // Frame 1: digits 1,2,3,4, colon on
        expect_at(kk(1, 0, 3),  "f1_ml4",         7'h19, 1'b1, 4'hE);
        expect_at(kk(1, 1, 15), "f1_mh3_last",    7'h30, 1'b1, 4'hD);
        expect_at(kk(1, 2, 1),  "f1_colon_blank", 7'h7F, 1'b1, 4'hF);
        expect_at(kk(1, 2, 4),  "f1_hl2_colon",   7'h24, 1'b0, 4'hB);
        expect_at(kk(1, 3, 0),  "f1_slot3_blank", 7'h7F, 1'b1, 4'hF);
        expect_at(kk(1, 3, 2),  "f1_hh1",         7'h79, 1'b1, 4'h7);
        // Frame 2: ml=5 latched, hh change mid-frame not yet visible, colon off
        expect_at(kk(2, 0, 7), "f2_ml5",       7'h12, 1'b1, 4'hE);
        expect_at(kk(2, 2, 6), "f2_colon_off", 7'h24, 1'b1, 4'hB);
        expect_at(kk(2, 3, 9), "f2_hh_frozen", 7'h79, 1'b1, 4'h7);
        // Frame 3: ml=7, hh=2, colon on
        expect_at(kk(3, 0, 4), "f3_ml7",       7'h78, 1'b1, 4'hE);
        expect_at(kk(3, 2, 3), "f3_colon_on",  7'h24, 1'b0, 4'hB);
        expect_at(kk(3, 3, 5), "f3_hh2",       7'h24, 1'b1, 4'h7);
        // Frame 4: blink slot 2, lead blank hh=0, colon off
        expect_at(kk(4, 1, 6), "f4_mh_unblinked", 7'h30, 1'b1, 4'hD);
        expect_at(kk(4, 2, 0), "f4_slot2_blank",  7'h7F, 1'b1, 4'hF);
        expect_at(kk(4, 2, 4), "f4_blinked",      7'h7F, 1'b1, 4'hB);
        expect_at(kk(4, 3, 4), "f4_lead_blank",   7'h7F, 1'b1, 4'h7);
        // Frame 5: colon on, blinked digit shown
        expect_at(kk(5, 2, 4), "f5_hl9_shown",    7'h10, 1'b0, 4'hB);
        expect_at(kk(5, 3, 4), "f5_lead_blank",   7'h7F, 1'b1, 4'h7);
        // Frame 6: non-BCD hour_low shows a dash
        expect_at(kk(6, 2, 3), "f6_dash",         7'h3F, 1'b1, 4'hB);

        rst = 1'b0;

        wait_cyc(kk(1, 1, 0));
        dif.min_low = 4'd5;

        wait_cyc(kk(2, 1, 5));
        dif.min_low   = 4'd7;
        dif.hour_high = 4'd2;

        wait_cyc(kk(3, 1, 0));
        dif.blink_mask = 4'b0100;
        dif.blank_lead = 1'b1;
        dif.hour_high  = 4'd0;
        dif.hour_low   = 4'd9;

        wait_cyc(kk(5, 1, 0));
        dif.hour_low   = 4'hC;
        dif.blink_mask = 4'b0000;

        // Asynchronous reset in the middle of a lit slot
        wait_cyc(kk(6, 2, 8));
        #1;
        check("sb_drained_before_reset", sb_q.size(), 0);
        rst = 1'b1;
        #1;
        check("async_reset_now", {20'd0, dif.seg, dif.dp, dif.dig_sel}, {20'd0, 7'h7F, 1'b1, 4'hF});
        repeat (2) @(negedge clk);
        check("async_reset_hold", {20'd0, dif.seg, dif.dp, dif.dig_sel}, {20'd0, 7'h7F, 1'b1, 4'hF});

        // After reset the snapshot is zeros again despite hour_low=C on the inputs
        expect_at(kk(0, 0, 1), "r_blank_c1",  7'h7F, 1'b1, 4'hF);
        expect_at(kk(0, 0, 2), "r_first_lit", 7'h40, 1'b1, 4'hE);
        expect_at(kk(0, 2, 4), "r_slot2",     7'h40, 1'b1, 4'hB);
        rst = 1'b0;

        wait_cyc(kk(0, 2, 4) + 2);
        begin
            int guard = 0;
            while (sb_q.size() > 0 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
        end
        check("sb_drained_final", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
